// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, optional parity, stop bit.
// Bit timing is derived from the shared 16x oversample tick; all outputs are registered.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       br_tick,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [4:0] OS_LAST   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    // Parity over the active data bits only; odd parity seeds the XOR with 1.
    function automatic logic calc_parity(input logic [7:0] data);
        logic p;
        p = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            p = p ^ data[i];
        end
        return p;
    endfunction

    state_t     r_state;
    logic [4:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic       w_tick_last;

    assign w_tick_last = br_tick &&
                         (r_tick_cnt == ((r_state == ST_STOP) ? STOP_LAST : OS_LAST));

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // Frame sequencer: tick counting, state transitions and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 5'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if ((r_state != ST_IDLE) && br_tick) begin
                r_tick_cnt <= w_tick_last ? 5'd0 : (r_tick_cnt + 5'd1);
            end

            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    // A tick coinciding with the accepted start is deliberately not counted.
                    if (start) begin
                        r_shift    <= tx_data;
                        r_parity   <= calc_parity(tx_data);
                        r_tick_cnt <= 5'd0;
                        r_bit_cnt  <= 3'd0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_tick_last) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_tick_last) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= 3'd0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_tick_last) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover default, even/odd parity and 7-bit/2-stop configs.
// br_tick fires every 4 clk, so one bit period is 64 clk.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       br_tick = 1'b0;
    logic [3:0] start_r = 4'd0;
    logic [7:0] data_r [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;
    int         done_cnt [4];
    int         tests_run = 0;
    int         tests_failed = 0;
    int         tick_cnt = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            data_r[i]   = 8'h00;
            done_cnt[i] = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            br_tick  = (tick_cnt == 3);
            tick_cnt = (tick_cnt + 1) % 4;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    uart_tx_frame u_def (
        .clk(clk), .reset(reset), .br_tick(br_tick), .start(start_r[0]), .tx_data(data_r[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .reset(reset), .br_tick(br_tick), .start(start_r[1]), .tx_data(data_r[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .br_tick(br_tick), .start(start_r[2]), .tx_data(data_r[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    uart_tx_frame #(.DATA_BITS(7), .STOP_TICKS(32)) u_d7 (
        .clk(clk), .reset(reset), .br_tick(br_tick), .start(start_r[3]), .tx_data(data_r[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    // Called at a negedge; start is high across exactly one posedge.
    task automatic pulse_start(input int idx, input logic [7:0] d);
        data_r[idx]  = d;
        start_r[idx] = 1'b1;
        @(negedge clk);
        start_r[idx] = 1'b0;
    endtask

    // Mid-bit receiver. done_off = negedges from stop mid-sample to tx_done (-1 if not seen).
    task automatic rx_frame(input int idx, input int nbits, input bit has_par, input int stop_clks,
                            output logic [7:0] data, output logic par, output logic frame_ok,
                            output int done_off);
        int n;
        data = 8'h00; par = 1'b0; frame_ok = 1'b1; done_off = -1;
        n = 0;
        while (tx_w[idx] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            frame_ok = 1'b0;
            return;
        end
        repeat (32) @(negedge clk);
        if (tx_w[idx] !== 1'b0) frame_ok = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            repeat (64) @(negedge clk);
            data[b] = tx_w[idx];
        end
        if (has_par) begin
            repeat (64) @(negedge clk);
            par = tx_w[idx];
        end
        repeat (64) @(negedge clk);
        if (tx_w[idx] !== 1'b1) frame_ok = 1'b0;
        n = 0;
        while (done_w[idx] !== 1'b1 && n < stop_clks) begin
            @(negedge clk);
            n++;
            if (tx_w[idx] !== 1'b1) frame_ok = 1'b0;
        end
        if (done_w[idx] === 1'b1) done_off = n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_w !== 4'hF) begin tests_failed++; $display("FAIL reset_tx: got %b want 1111", tx_w); end
        tests_run++;
        if (busy_w !== 4'h0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0000", busy_w); end
        tests_run++;
        if (done_w !== 4'h0) begin tests_failed++; $display("FAIL reset_done: got %b want 0000", done_w); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_55();
        int   runlen [9];
        int   runs, len, n, d0;
        logic level;
        bit   busy_ok, stop_ok, len_ok;
        d0 = done_cnt[0];
        pulse_start(0, 8'h55);
        tests_run++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL f55_accept: tx=%b busy=%b want tx=0 busy=1", tx_w[0], busy_w[0]);
        end
        level = 1'b0; len = 1; runs = 0; n = 0; busy_ok = 1'b1;
        while (runs < 9 && n < 2000) begin
            @(negedge clk);
            n++;
            if (busy_w[0] !== 1'b1) busy_ok = 1'b0;
            if (tx_w[0] !== level) begin
                runlen[runs] = len;
                runs++;
                level = tx_w[0];
                len = 1;
            end else begin
                len++;
            end
        end
        tests_run++;
        if (runs != 9) begin tests_failed++; $display("FAIL f55_runs: got %0d transitions want 9", runs); end
        tests_run++;
        if (runlen[0] < 61 || runlen[0] > 64) begin
            tests_failed++; $display("FAIL f55_start_len: got %0d want 61..64", runlen[0]);
        end
        len_ok = 1'b1;
        for (int i = 1; i < 9; i++) if (runlen[i] != 64) len_ok = 1'b0;
        tests_run++;
        if (!len_ok) begin
            tests_failed++;
            $display("FAIL f55_bit_len: got %0d %0d %0d %0d %0d %0d %0d %0d want all 64", runlen[1],
                     runlen[2], runlen[3], runlen[4], runlen[5], runlen[6], runlen[7], runlen[8]);
        end
        n = 0; stop_ok = 1'b1;
        while (done_w[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (tx_w[0] !== 1'b1) stop_ok = 1'b0;
            if (done_w[0] !== 1'b1 && busy_w[0] !== 1'b1) busy_ok = 1'b0;
        end
        tests_run++;
        if (n != 64 || !stop_ok) begin
            tests_failed++; $display("FAIL f55_stop: done after %0d clk line_ok=%b want 64 and 1", n, stop_ok);
        end
        tests_run++;
        if (busy_w[0] !== 1'b0) begin tests_failed++; $display("FAIL f55_busy_at_done: got %b want 0", busy_w[0]); end
        tests_run++;
        if (!busy_ok) begin tests_failed++; $display("FAIL f55_busy_frame: busy dropped during frame"); end
        @(negedge clk);
        tests_run++;
        if (done_w[0] !== 1'b0) begin tests_failed++; $display("FAIL f55_done_width: got %b want 0", done_w[0]); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (done_cnt[0] - d0 != 1) begin
            tests_failed++; $display("FAIL f55_done_count: got %0d want 1", done_cnt[0] - d0);
        end
    endtask

    task automatic check_parity(input int idx, input logic [7:0] d, input logic exp_par, input string nm);
        logic [7:0] data; logic par, ok; int off;
        pulse_start(idx, d);
        rx_frame(idx, 8, 1'b1, 64, data, par, ok, off);
        tests_run++;
        if (!ok || data !== d || par !== exp_par || off < 29 || off > 32) begin
            tests_failed++;
            $display("FAIL %s: data=%h par=%b ok=%b done_off=%0d want data=%h par=%b ok=1 done_off=29..32",
                     nm, data, par, ok, off, d, exp_par);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_parity();
        check_parity(1, 8'h07, 1'b1, "par_even_07");
        check_parity(2, 8'h07, 1'b0, "par_odd_07");
        check_parity(1, 8'hA5, 1'b0, "par_even_A5");
    endtask

    task automatic test_back_to_back();
        logic [7:0] data; logic par, ok; int off;
        pulse_start(0, 8'h3C);
        rx_frame(0, 8, 1'b0, 64, data, par, ok, off);
        tests_run++;
        if (!ok || data !== 8'h3C || off < 29 || off > 32) begin
            tests_failed++; $display("FAIL b2b_first: data=%h ok=%b done_off=%0d want 3c 1 29..32", data, ok, off);
        end
        pulse_start(0, 8'hC3);
        tests_run++;
        if (tx_w[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: tx=%b want 0 right after done cycle", tx_w[0]); end
        rx_frame(0, 8, 1'b0, 64, data, par, ok, off);
        tests_run++;
        if (!ok || data !== 8'hC3 || off < 29 || off > 32) begin
            tests_failed++; $display("FAIL b2b_second: data=%h ok=%b done_off=%0d want c3 1 29..32", data, ok, off);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        logic [7:0] data; logic par, ok; int off, d0; bit idle_ok;
        d0 = done_cnt[0];
        pulse_start(0, 8'h12);
        fork
            rx_frame(0, 8, 1'b0, 64, data, par, ok, off);
            begin
                repeat (200) @(negedge clk);
                pulse_start(0, 8'hFF);
                data_r[0] = 8'hFF;
            end
        join
        tests_run++;
        if (!ok || data !== 8'h12) begin
            tests_failed++; $display("FAIL busy_frame: data=%h ok=%b want 12 1", data, ok);
        end
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) idle_ok = 1'b0;
        end
        tests_run++;
        if (!idle_ok) begin tests_failed++; $display("FAIL busy_no_second: line left idle after frame"); end
        tests_run++;
        if (done_cnt[0] - d0 != 1) begin
            tests_failed++; $display("FAIL busy_done_count: got %0d want 1", done_cnt[0] - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] data; logic par, ok; int off, d0;
        pulse_start(0, 8'h00);
        repeat (4 * 64 + 32) @(negedge clk);
        tests_run++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_pre: tx=%b busy=%b want 0 1", tx_w[0], busy_w[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_post: tx=%b busy=%b done=%b want 1 0 0", tx_w[0], busy_w[0], done_w[0]);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt[0];
        pulse_start(0, 8'hA0);
        rx_frame(0, 8, 1'b0, 64, data, par, ok, off);
        repeat (4) @(negedge clk);
        tests_run++;
        if (!ok || data !== 8'hA0 || off < 29 || off > 32 || done_cnt[0] - d0 != 1) begin
            tests_failed++;
            $display("FAIL rst_mid_next: data=%h ok=%b done_off=%0d dones=%0d want a0 1 29..32 1",
                     data, ok, off, done_cnt[0] - d0);
        end
    endtask

    task automatic test_data7_stop32();
        logic [7:0] data; logic par, ok; int off;
        pulse_start(3, 8'hFF);
        rx_frame(3, 7, 1'b0, 128, data, par, ok, off);
        tests_run++;
        if (!ok || data !== 8'h7F) begin
            tests_failed++; $display("FAIL d7_data: data=%h ok=%b want 7f 1", data, ok);
        end
        tests_run++;
        if (off < 93 || off > 96) begin
            tests_failed++; $display("FAIL d7_stop_len: done_off=%0d want 93..96", off);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame_55();
        test_parity();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_frame();
        test_data7_stop32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter that serialises one byte per request into a standard asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity bit, stop bit. It shares the baud generator's 16x oversample tick (br_tick) with the receive path and drives the board TX pin. The host loads a byte with a single-cycle start strobe. A one-cycle tx_done pulse signals frame completion so a sender FSM or FIFO can chain frames back to back.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8); tx_data bits above DATA_BITS-1 are ignored
OVERSAMPLE, 16, br_tick pulses per bit period
PARITY_EN, 0, 1 = insert parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
STOP_TICKS, 16, br_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2); range OVERSAMPLE..32

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
br_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
start  input  1  one-clk request to send tx_data; sampled only in IDLE
tx_data  input  8  byte to transmit; captured on the accepted start
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high from the cycle after start is accepted until the frame ends
tx_done  output  1  one-clk pulse when the stop bit completes

Behaviour:
- One clock: clk. Reset is synchronous and active-high.
- Reset: on any clk edge with reset=1: state=IDLE, tx=1, tx_busy=0, tx_done=0, tick and bit counters=0, shift register=0. A reset mid-frame aborts the frame immediately, and tx is high at the next edge.
- All outputs are registered. There is no combinational path from any input to tx, tx_busy or tx_done.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0. When start=1: capture tx_data into the shift register, compute the parity bit from tx_data[DATA_BITS-1:0], clear the tick counter, go to START. tx=0 and tx_busy=1 from the next edge.
- Bit timing: in each non-IDLE state, the tick counter increments on every br_tick. The state advances on the br_tick where the counter equals its terminal value (OVERSAMPLE-1, or STOP_TICKS-1 in STOP), and the counter returns to 0.
- Start bit: from acceptance to the OVERSAMPLE-th br_tick.
- START -> DATA on the terminal tick. tx becomes shift[0].
- DATA: on each terminal tick, shift right by one and increment the bit counter; tx follows the new shift[0]. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR of the data bits, inverted when PARITY_ODD=1. Terminal tick -> STOP.
- STOP: tx=1. On the terminal tick (STOP_TICKS-1): go to IDLE, tx_done=1 for exactly one clk, tx_busy=0 in the same cycle.
- Back-to-back frames: start is sampled whenever state=IDLE, including the cycle in which tx_done is high. Accepting it there gives zero idle gap after the stop bit.
- start while busy: ignored. It is not queued, and tx_data changes while busy have no effect on the current frame.
- br_tick and start in the same IDLE cycle: start is accepted, and that br_tick is not counted.
- br_tick stuck low: the FSM holds its state and tx indefinitely. No timeout.
- Width rules: tick counter 5 bits, bit counter 3 bits. Counters never exceed their terminal value.

Test Plan:
- Frame 0x55, defaults, br_tick every 4 clk -> tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit 64 clk after the start bit; tx_done pulses once for 1 clk; tx_busy high throughout the frame.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. Same with PARITY_ODD=1 -> parity bit 0. Byte 0xA5, even parity -> parity bit 0. Frame is 11 bits.
- Back-to-back: assert start with 0x3C in the tx_done cycle, then 0xC3 -> no high gap beyond the stop bit; the receiver model decodes 0x3C, 0xC3.
- start pulsed mid-frame with tx_data=0xFF while sending 0x12 -> the line carries only 0x12; no second frame and no extra tx_done.
- Reset asserted during DATA bit 3 -> next edge: tx=1, tx_busy=0, tx_done=0. A subsequent start with 0xA0 sends a clean full frame.
- DATA_BITS=7, STOP_TICKS=32, byte 0xFF -> 7 data ones, bit 7 not sent, stop bit lasts 32 br_ticks, tx_done at the 32nd.
